// File: rtl/gp_sar_adc_ctrl.sv
// gp_sar_adc_ctrl: SAR ADC controller driving GP_DAC code and GP_ACMP power, MSB-first; `GP_SAR_ADC_CMP_SYNC_EN adds a 2-flop CMP_IN synchronizer
module gp_sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int PWRUP_CYCLES  = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             START,
  input  logic             PWRDN,
  input  logic             CMP_IN,
  output logic             ACMP_PWREN,
  output logic [WIDTH-1:0] DAC_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);
`ifdef GP_SAR_ADC_CMP_SYNC_EN
  localparam int W = SETTLE_CYCLES + 2;
`else
  localparam int W = SETTLE_CYCLES;
`endif
  localparam int CMAX = PWRUP_CYCLES > W ? PWRUP_CYCLES : W;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_PWRUP, S_TRIAL, S_DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] code_q, code_d, result_q, result_d, trial;
  logic             cmp;
  assign trial = code_q | (WIDTH'(1) << bit_q);
`ifdef GP_SAR_ADC_CMP_SYNC_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], CMP_IN};
  assign cmp    = sync_q[1];
  // two-stage synchronizer for the asynchronous comparator output
  always_ff @(posedge CLK)
    sync_q <= !nRST ? 2'b00 : sync_d;
`else
  assign cmp = CMP_IN;
`endif
  // state register and datapath flops
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      code_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      code_q   <= code_d;
      result_q <= result_d;
    end
  end
  // next state: power-up wait, then one bit decided per W-cycle trial; PWRDN aborts
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    code_d   = code_q;
    result_d = result_q;
    if (PWRDN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          state_d = S_PWRUP;
          cnt_d   = '0;
          code_d  = '0;
        end
        S_PWRUP: if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
          state_d = S_TRIAL;
          cnt_d   = '0;
          bit_d   = BW'(WIDTH - 1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        S_TRIAL: if (cnt_q == CW'(W - 1)) begin
          cnt_d  = '0;
          code_d = cmp ? trial : code_q;
          if (bit_q == '0) begin
            state_d  = S_DONE;
            result_d = code_d;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  // outputs decoded from the current state
  always_comb begin
    ACMP_PWREN = state_q inside {S_PWRUP, S_TRIAL};
    BUSY       = state_q inside {S_PWRUP, S_TRIAL};
    DONE       = state_q == S_DONE;
    DAC_OUT    = state_q == S_TRIAL ? trial : state_q == S_DONE ? code_q : '0;
    RESULT     = result_q;
  end
endmodule

// File: tb/tb_gp_sar_adc_ctrl.sv
// tb_gp_sar_adc_ctrl: randomized self-checking bench with an ideal-comparator SAR reference model
module tb_gp_sar_adc_ctrl;
  localparam int WIDTH = 8;
  localparam int P     = 8;
  localparam int S     = 4;
`ifdef GP_SAR_ADC_CMP_SYNC_EN
  localparam int W = S + 2;
`else
  localparam int W = S;
`endif
  localparam int CONV = P + WIDTH * W;
  logic             clk = 0;
  logic             n_rst = 0;
  logic             start = 0;
  logic             pwrdn = 0;
  logic             cmp_in;
  logic             acmp_pwren;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dac_out;
  logic [WIDTH-1:0] result;
  int               vin = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               prev = 0;
  int               cyc;
  always #5 clk = ~clk;
  assign cmp_in = vin >= int'(dac_out);
  gp_sar_adc_ctrl #(.WIDTH(WIDTH), .PWRUP_CYCLES(P), .SETTLE_CYCLES(S)) dut (
    .CLK(clk), .nRST(n_rst), .START(start), .PWRDN(pwrdn), .CMP_IN(cmp_in),
    .ACMP_PWREN(acmp_pwren), .DAC_OUT(dac_out), .BUSY(busy), .DONE(done), .RESULT(result)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask
  // ideal SAR: kept bits above i equal vin's bits, plus the bit under trial
  function automatic int trial_code(input int v, input int i);
    return ((v >> (i + 1)) << (i + 1)) | (1 << i);
  endfunction
  task automatic check_idle(input string tag, input int res);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pwren"}, acmp_pwren, 0);
    check({tag, "_dac"}, dac_out, 0);
    check({tag, "_result"}, result, res);
  endtask
  task automatic kick(input int v);
    vin = v;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic convert(input int v, input bit poke);
    int exp_dac;
    kick(v);
    for (int c = 1; c <= CONV + 4; c++) begin
      if (c > 1) @(negedge clk);
      exp_dac = c <= P ? 0 : c <= CONV ? trial_code(v, WIDTH - 1 - (c - P - 1) / W) : c == CONV + 1 ? v : 0;
      check("busy", busy, c <= CONV);
      check("pwren", acmp_pwren, c <= CONV);
      check("done", done, c == CONV + 1);
      check("dac", dac_out, exp_dac);
      check("result", result, c >= CONV + 1 ? v : prev);
      start = poke && c <= CONV + 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    prev = v;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4 * CONV);
    if (!done) check("done_timeout", 0, 1);
  endtask
  task automatic abort(input int v, input int at);
    kick(v);
    repeat (at - 1) @(negedge clk);
    check("abort_busy_before", busy, 1);
    pwrdn = 1;
    @(negedge clk);
    pwrdn = 0;
    check_idle("abort", prev);
    repeat (CONV + 2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset", 0);
    n_rst = 1;
    convert('hA5, 0);
    convert('h00, 0);
    convert('hFF, 1);
    repeat (4) convert(int'($urandom_range(0, 255)), 1);
    vin = 'h3C;
    @(negedge clk);
    start = 1;
    wait_done(cyc);
    check("held_result", result, 'h3C);
    repeat (3) begin
      wait_done(cyc);
      check("held_period", cyc, CONV + 2);
      check("held_result", result, 'h3C);
    end
    start = 0;
    @(negedge clk);
    check_idle("held_stop", 'h3C);
    prev = 'h3C;
    abort(int'($urandom_range(0, 255)), P + 3 * W + 2);
    pwrdn = 1;
    start = 1;
    repeat (5) begin
      @(negedge clk);
      check("pwrdn_blocks_start", busy, 0);
    end
    pwrdn = 0;
    start = 0;
    abort(int'($urandom_range(0, 255)), CONV);
    abort(int'($urandom_range(0, 255)), 1);
    kick('h77);
    repeat (12) @(negedge clk);
    n_rst = 0;
    @(negedge clk);
    n_rst = 1;
    check_idle("midreset", 0);
    prev = 0;
    convert('h5A, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
